// File: rtl/uart_reg_responder.sv
// Host command responder: 'W' addr data -> 'K', 'R' addr -> value, anything rejected -> 'E'.
// Define UART_RSP_CHKSUM_EN to require a trailing XOR checksum byte on every command.
module uart_reg_responder #(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [7:0] ctrl_out,
  output logic       cmd_err
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_RSP_CHKSUM_EN
    GET_CHK,
`endif
    EXEC,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE
  } state_t;

`ifdef UART_RSP_CHKSUM_EN
  localparam state_t PAYLOAD_DONE = GET_CHK;
`else
  localparam state_t PAYLOAD_DONE = EXEC;
`endif

  state_t        state, state_next;
  logic          is_write;
  logic [7:0]    addr, data, rsp;
  logic [7:0]    regs [NUM_REGS];
  logic [TW-1:0] tcnt, tcnt_inc;
  logic [AW-1:0] idx;
  logic          collecting, timeout_hit, addr_ok, cmd_ok;

  assign idx     = addr[AW-1:0];
  assign addr_ok = 32'(addr) < NUM_REGS;

`ifdef UART_RSP_CHKSUM_EN
  logic [7:0] chk_acc;
  logic       chk_ok;
  assign cmd_ok = addr_ok && chk_ok;
`else
  assign cmd_ok = addr_ok;
`endif

  always_comb begin
    collecting = (state == GET_ADDR) || (state == GET_DATA);
`ifdef UART_RSP_CHKSUM_EN
    if (state == GET_CHK) collecting = 1'b1;
`endif
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign tcnt_inc    = (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + TW'(1);
  assign timeout_hit = collecting && !rx_done && (tcnt_inc == TW'(TIMEOUT_CYCLES));

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (rx_done) state_next = (rx_data == OP_WRITE || rx_data == OP_READ) ? GET_ADDR : SEND;
      GET_ADDR:  if (rx_done) state_next = is_write ? GET_DATA : PAYLOAD_DONE;
      GET_DATA:  if (rx_done) state_next = PAYLOAD_DONE;
`ifdef UART_RSP_CHKSUM_EN
      GET_CHK:   if (rx_done) state_next = EXEC;
`endif
      EXEC:      state_next = SEND;
      SEND:      if (!tx_busy) state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_next = WAIT_IDLE;
      WAIT_IDLE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (timeout_hit) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is cleared on reset because reads after reset must return 0x00.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      is_write <= 1'b0;
      addr     <= '0;
      data     <= '0;
      rsp      <= '0;
      tcnt     <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      ctrl_out <= '0;
      cmd_err  <= 1'b0;
`ifdef UART_RSP_CHKSUM_EN
      chk_acc  <= '0;
      chk_ok   <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      cmd_err  <= timeout_hit;
      ctrl_out <= regs[0];
      tcnt     <= (collecting && !rx_done) ? tcnt_inc : '0;
      case (state)
        IDLE: if (rx_done) begin
          is_write <= (rx_data == OP_WRITE);
          if (rx_data != OP_WRITE && rx_data != OP_READ) begin
            rsp     <= RSP_ERR;
            cmd_err <= 1'b1;
          end
`ifdef UART_RSP_CHKSUM_EN
          chk_acc <= rx_data;
`endif
        end
        GET_ADDR: if (rx_done) begin
          addr <= rx_data;
`ifdef UART_RSP_CHKSUM_EN
          chk_acc <= chk_acc ^ rx_data;
`endif
        end
        GET_DATA: if (rx_done) begin
          data <= rx_data;
`ifdef UART_RSP_CHKSUM_EN
          chk_acc <= chk_acc ^ rx_data;
`endif
        end
`ifdef UART_RSP_CHKSUM_EN
        GET_CHK: if (rx_done) chk_ok <= (rx_data == chk_acc);
`endif
        EXEC: begin
          if (!cmd_ok) begin
            rsp     <= RSP_ERR;
            cmd_err <= 1'b1;
          end else if (is_write) begin
            regs[idx] <= data;
            rsp       <= RSP_OK;
          end else begin
            rsp <= regs[idx];
          end
        end
        SEND: if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data  <= rsp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
Device-side command responder for the UART link. It consumes the received byte stream (rx_data/rx_done) from the host, decodes register read and write commands, and executes them on an internal byte-wide register file. It returns one response byte per command through the transmitter handshake (tx_start/tx_data/tx_busy). Register 0 drives a control output for the rest of the design.

Parameters:
NUM_REGS, 16, number of 8-bit registers; power of two, 2..256
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of one command before it is aborted (20 ms at 50 MHz)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte; valid when rx_done=1
rx_done  input  1  one-cycle strobe per received byte
tx_busy  input  1  transmitter busy
tx_start  output  1  one-cycle request to send tx_data
tx_data  output  8  response byte; held stable from tx_start until the transmitter returns idle
ctrl_out  output  8  continuous copy of register 0
cmd_err  output  1  one-cycle pulse on any rejected or aborted command

Behaviour:
- Reset: synchronous, active-high. Takes effect on any clk edge with reset=1 and has priority over all other activity, including mid-command and mid-response.
- Reset values: tx_start=0, tx_data=0x00, ctrl_out=0x00, cmd_err=0, all registers 0x00, state IDLE, timeout counter 0.
- Protocol:
  - Write: 'W'(0x57), addr, data -> 'K'(0x4B).
  - Read: 'R'(0x52), addr -> register value.
  - Error: any failure -> 'E'(0x45).
- Address legality: address must be < NUM_REGS. Any set upper bit gives 'E', with no register change.
- FSM states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_BUSY, WAIT_IDLE.
- IDLE:
  - rx_done with 0x57 or 0x52: latch opcode, go to GET_ADDR.
  - rx_done with any other byte: response 'E', cmd_err pulse, go to SEND.
- GET_ADDR: on rx_done, latch addr. Write -> GET_DATA; read -> EXEC.
- GET_DATA: on rx_done, latch data, go to EXEC.
- EXEC (exactly one cycle):
  - Legal write: register updated this cycle, response 'K'.
  - Legal read: response = register value; the read happens after any write in the same command.
  - Illegal address: response 'E', cmd_err pulse.
  - Next state: SEND.
- SEND:
  - tx_busy=0: drive tx_data, pulse tx_start for one cycle, go to WAIT_BUSY.
  - tx_busy=1: wait in SEND.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_IDLE.
- WAIT_IDLE: wait for tx_busy=0, then go to IDLE.
- ctrl_out reflects a register-0 write on the clock edge after EXEC (registered copy).
- Latency: last command byte rx_done -> tx_start = 3 cycles (EXEC, SEND, then tx_start asserted) when the transmitter is idle.
- Timeout:
  - Counter is cleared on every rx_done and in IDLE; it counts in GET_ADDR and GET_DATA.
  - When the count reaches TIMEOUT_CYCLES: abort to IDLE, cmd_err pulse, no response, no register change.
  - rx_done in the same cycle as expiry: the byte is accepted and the timeout is ignored.
- rx_done in EXEC, SEND, WAIT_BUSY or WAIT_IDLE: byte dropped. The link is half-duplex; the host waits for the response.
- Counters: the timeout counter saturates and never wraps. Width is clog2(TIMEOUT_CYCLES+1).

Optional Feature:
UART_RSP_CHKSUM_EN
- Defined:
  - Each command carries a trailing checksum byte: XOR of all preceding command bytes (opcode, addr, data).
  - Extra state GET_CHK is entered after the last payload byte, subject to the same timeout.
  - On mismatch: response 'E', cmd_err pulse, no register write.
- Undefined: no checksum byte; GET_CHK does not exist.
- The response format is identical in both builds.

Test Plan:
- Write then read: 'W',0x03,0xA5 -> 'K'; then 'R',0x03 -> tx_data=0xA5; cmd_err stays 0.
- Control write: 'W',0x00,0x3C -> ctrl_out=0x3C on the cycle after EXEC; response 'K'.
- Bad inputs: 'R',0x10 (NUM_REGS=16) -> 'E' plus cmd_err pulse. Stray 0x41 in IDLE -> 'E'. Registers unchanged in both cases.
- Timeout (TIMEOUT_CYCLES=50): 'W',0x02 then silence -> after 50 cycles cmd_err pulses, state returns to IDLE, no tx_start. Next 'R',0x02 -> 0x00.
- Handshake: hold tx_busy=1 for 200 cycles after a command completes -> tx_start deferred until tx_busy falls. Bytes arriving during the response are dropped.
- Reset while in GET_DATA with reg5=0x77 -> all registers 0 and state IDLE. With UART_RSP_CHKSUM_EN: 'W',0x01,0x10,0x46 -> 'K'; checksum 0x47 -> 'E'.
